bet_round_controller: RTL and testbench
=======================================

BET_ROUND_CONTROLLER -- requirements
Module: bet_round_controller

Interface
REQ-001 SHALL have parameter MAX_BETS, default 12: number of bet slots per round (1..15).
REQ-002 SHALL have parameter SPIN_TIMEOUT, default 32'd500_000_000: SPIN cycles before a forced exit.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 16'd1000: SETTLE dwell in cycles.
REQ-004 SHALL have these ports (name, direction, width, meaning):
  clock  in  1  single system clock; all logic on its rising edge.
  reset  in  1  synchronous, active-low reset.
  key_valid  in  1  keyboard byte-ready level/pulse from the PS/2 controller.
  bet_opcode  in  6  decoded keyboard opcode; 6'b111110 = SPIN command, 6'b111111 = no-op.
  chip_color  in  3  chip color from Arduino; 3'b000 = no chip present.
  spin_done  in  1  wheel/processor result-ready strobe.
  bet_slot_we  out  1  one-cycle write strobe to the bet register bank.
  bet_slot_idx  out  4  slot index written (0..MAX_BETS-1).
  bet_slot_data  out  8  {chip_color[1:0], bet_opcode}.
  bet_count  out  4  bets accepted this round.
  spin_check  out  1  high for the whole SPIN state.
  round_state  out  2  0 IDLE, 1 BETTING, 2 SPIN, 3 SETTLE.
  bet_rejected  out  1  one-cycle pulse on a refused key event.
  clear_bets  out  1  one-cycle pulse when a round ends.
  spin_timeout  out  1  sticky; set when SPIN exits by timeout.

Function
REQ-005 SHALL define a key event as a cycle with key_valid=1 and registered previous key_valid=0; each key press yields at most one event.
REQ-006 SHALL classify an event by bet_opcode: 111111 -> ignored (no outputs), 111110 -> spin request, other -> bet request.
REQ-007 SHALL accept a bet request only when state is IDLE or BETTING, chip_color != 0, and bet_count < MAX_BETS.
REQ-008 SHALL, for an accepted bet in cycle N, assert bet_slot_we in cycle N+1 for exactly one cycle, with bet_slot_idx = old bet_count and bet_slot_data = {chip_color[1:0], bet_opcode} as sampled in cycle N. bet_count SHALL increment at the same edge.
REQ-009 SHALL move IDLE -> BETTING on the first accepted bet.
REQ-010 SHALL pulse bet_rejected in cycle N+1 for any bet request that fails REQ-007, and for a spin request in IDLE, SPIN or SETTLE.
REQ-011 SHALL move BETTING -> SPIN on a spin request with bet_count >= 1. It SHALL clear the spin cycle counter and clear spin_timeout on entry.
REQ-012 SHALL hold spin_check=1 in every cycle in which round_state=SPIN, and 0 otherwise.
REQ-013 SHALL move SPIN -> SETTLE on the first cycle with spin_done=1. If that never occurs, it SHALL move after SPIN_TIMEOUT SPIN cycles and set spin_timeout.
REQ-014 SHALL stay in SETTLE for SETTLE_CYCLES cycles, then pulse clear_bets for one cycle, reset bet_count to 0 and enter IDLE at the same edge.
REQ-015 SHALL ignore spin_done outside SPIN.
REQ-016 SHALL give precedence to the state transition when spin_done and a key event coincide in SPIN; the key event SHALL be rejected.
REQ-017 SHALL hold bet_count at MAX_BETS when full; further bets SHALL be rejected and the slot index SHALL never wrap.
REQ-018 SHALL register all outputs; no output SHALL depend combinationally on any input.

Reset
REQ-019 SHALL, while reset=0 at a clock edge, set state IDLE, bet_count 0, counters 0, spin_timeout 0, and bet_slot_we, bet_slot_idx, bet_slot_data, bet_rejected, clear_bets and spin_check to 0.
REQ-020 SHALL load the previous-key_valid register with 1 during reset, so a key held across reset release produces no event.
REQ-021 SHALL abandon any round on reset mid-operation, with no clear_bets pulse and no bet write.

Verification
REQ-022 Bet then spin: events opcode 6'd5 with color 3'b001, then opcode 6'b111110 -> one write (idx 0, data 8'h45), round_state 1 then 2, spin_check=1.
REQ-023 Fill and overflow: 13 bets with color 3'b010 -> idx 0..11 written, bet_count=12, 13th event gives bet_rejected and no write.
REQ-024 Invalid events: color 3'b000 bet -> rejected. Spin request in IDLE -> rejected, state stays 0. Opcode 6'b111111 -> no pulse of any kind.
REQ-025 Completion: spin_done in SPIN -> SETTLE for SETTLE_CYCLES, then one clear_bets pulse, bet_count=0, IDLE. With SPIN_TIMEOUT=20 and no spin_done -> exit after 20 cycles with spin_timeout=1.
REQ-026 Edge and reset: key_valid held high for 10 cycles -> exactly one write. Reset asserted in SPIN with key_valid=1 held through release -> all outputs 0, IDLE, no event after release.

Source files
------------

// File: rtl/bet_round_controller.sv
// Round sequencer for a betting table: collects keyboard bets into a slot bank,
// runs the spin phase with a timeout, then dwells in settle before clearing the round.
module bet_round_controller #(
    parameter int          MAX_BETS      = 12,
    parameter logic [31:0] SPIN_TIMEOUT  = 32'd500_000_000,
    parameter logic [15:0] SETTLE_CYCLES = 16'd1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [5:0] bet_opcode,
    input  logic [2:0] chip_color,
    input  logic       spin_done,
    output logic       bet_slot_we,
    output logic [3:0] bet_slot_idx,
    output logic [7:0] bet_slot_data,
    output logic [3:0] bet_count,
    output logic       spin_check,
    output logic [1:0] round_state,
    output logic       bet_rejected,
    output logic       clear_bets,
    output logic       spin_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BETTING = 2'd1,
        ST_SPIN    = 2'd2,
        ST_SETTLE  = 2'd3
    } state_t;

    localparam logic [3:0] MAX_BETS_L = 4'(MAX_BETS);
    localparam logic [5:0] OP_SPIN    = 6'b111110;
    localparam logic [5:0] OP_NOOP    = 6'b111111;

    state_t      state_q, state_d;
    logic        key_prev_q, key_prev_d;
    logic [3:0]  bet_count_q, bet_count_d;
    logic [31:0] spin_cnt_q, spin_cnt_d;
    logic [15:0] settle_cnt_q, settle_cnt_d;
    logic        spin_timeout_q, spin_timeout_d;
    logic        bet_slot_we_q, bet_slot_we_d;
    logic [3:0]  bet_slot_idx_q, bet_slot_idx_d;
    logic [7:0]  bet_slot_data_q, bet_slot_data_d;
    logic        bet_rejected_q, bet_rejected_d;
    logic        clear_bets_q, clear_bets_d;
    logic        spin_check_q, spin_check_d;

    logic key_event;
    logic is_spin_req;
    logic is_bet_req;
    logic bet_ok;

    always_comb begin
        key_event   = key_valid & ~key_prev_q;
        is_spin_req = key_event && (bet_opcode == OP_SPIN);
        is_bet_req  = key_event && (bet_opcode != OP_SPIN) && (bet_opcode != OP_NOOP);
        bet_ok      = (chip_color != 3'b000) && (bet_count_q < MAX_BETS_L);

        state_d         = state_q;
        key_prev_d      = key_valid;
        bet_count_d     = bet_count_q;
        spin_cnt_d      = spin_cnt_q;
        settle_cnt_d    = settle_cnt_q;
        spin_timeout_d  = spin_timeout_q;
        bet_slot_we_d   = 1'b0;
        bet_slot_idx_d  = bet_slot_idx_q;
        bet_slot_data_d = bet_slot_data_q;
        bet_rejected_d  = 1'b0;
        clear_bets_d    = 1'b0;

        case (state_q)
            ST_IDLE, ST_BETTING: begin
                if (is_bet_req) begin
                    if (bet_ok) begin
                        bet_slot_we_d   = 1'b1;
                        bet_slot_idx_d  = bet_count_q;
                        bet_slot_data_d = {chip_color[1:0], bet_opcode};
                        bet_count_d     = bet_count_q + 4'd1;
                        state_d         = ST_BETTING;
                    end else begin
                        bet_rejected_d = 1'b1;
                    end
                end else if (is_spin_req) begin
                    if (state_q == ST_BETTING && bet_count_q != 4'd0) begin
                        state_d        = ST_SPIN;
                        spin_cnt_d     = 32'd0;
                        spin_timeout_d = 1'b0;
                    end else begin
                        bet_rejected_d = 1'b1;
                    end
                end
            end
            ST_SPIN: begin
                // Any key event during the spin is refused, including one that
                // coincides with the result strobe.
                bet_rejected_d = is_bet_req | is_spin_req;
                if (spin_done) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = 16'd0;
                end else if (spin_cnt_q >= SPIN_TIMEOUT - 32'd1) begin
                    state_d        = ST_SETTLE;
                    settle_cnt_d   = 16'd0;
                    spin_timeout_d = 1'b1;
                end else begin
                    spin_cnt_d = spin_cnt_q + 32'd1;
                end
            end
            ST_SETTLE: begin
                bet_rejected_d = is_bet_req | is_spin_req;
                if (settle_cnt_q >= SETTLE_CYCLES - 16'd1) begin
                    state_d      = ST_IDLE;
                    clear_bets_d = 1'b1;
                    bet_count_d  = 4'd0;
                    settle_cnt_d = 16'd0;
                end else begin
                    settle_cnt_d = settle_cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        spin_check_d = (state_d == ST_SPIN);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            // Treat a key held across reset release as already seen.
            key_prev_q      <= 1'b1;
            bet_count_q     <= 4'd0;
            spin_cnt_q      <= 32'd0;
            settle_cnt_q    <= 16'd0;
            spin_timeout_q  <= 1'b0;
            bet_slot_we_q   <= 1'b0;
            bet_slot_idx_q  <= 4'd0;
            bet_slot_data_q <= 8'd0;
            bet_rejected_q  <= 1'b0;
            clear_bets_q    <= 1'b0;
            spin_check_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            key_prev_q      <= key_prev_d;
            bet_count_q     <= bet_count_d;
            spin_cnt_q      <= spin_cnt_d;
            settle_cnt_q    <= settle_cnt_d;
            spin_timeout_q  <= spin_timeout_d;
            bet_slot_we_q   <= bet_slot_we_d;
            bet_slot_idx_q  <= bet_slot_idx_d;
            bet_slot_data_q <= bet_slot_data_d;
            bet_rejected_q  <= bet_rejected_d;
            clear_bets_q    <= clear_bets_d;
            spin_check_q    <= spin_check_d;
        end
    end

    assign bet_slot_we   = bet_slot_we_q;
    assign bet_slot_idx  = bet_slot_idx_q;
    assign bet_slot_data = bet_slot_data_q;
    assign bet_count     = bet_count_q;
    assign spin_check    = spin_check_q;
    assign round_state   = state_q;
    assign bet_rejected  = bet_rejected_q;
    assign clear_bets    = clear_bets_q;
    assign spin_timeout  = spin_timeout_q;

endmodule

// File: tb/tb_bet_round_controller.sv
// Randomised scoreboard bench for bet_round_controller: a round-level model predicts
// every output pulse (with its cycle), and a monitor matches the DUT's pulses against it.
module tb_bet_round_controller;

    localparam int MAXB = 12;
    localparam int T_SPIN = 20;
    localparam int S_SET = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [5:0] bet_opcode;
    logic [2:0] chip_color;
    logic       spin_done;
    logic       bet_slot_we;
    logic [3:0] bet_slot_idx;
    logic [7:0] bet_slot_data;
    logic [3:0] bet_count;
    logic       spin_check;
    logic [1:0] round_state;
    logic       bet_rejected;
    logic       clear_bets;
    logic       spin_timeout;

    bet_round_controller #(
        .MAX_BETS     (MAXB),
        .SPIN_TIMEOUT (32'(T_SPIN)),
        .SETTLE_CYCLES(16'(S_SET))
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .key_valid    (key_valid),
        .bet_opcode   (bet_opcode),
        .chip_color   (chip_color),
        .spin_done    (spin_done),
        .bet_slot_we  (bet_slot_we),
        .bet_slot_idx (bet_slot_idx),
        .bet_slot_data(bet_slot_data),
        .bet_count    (bet_count),
        .spin_check   (spin_check),
        .round_state  (round_state),
        .bet_rejected (bet_rejected),
        .clear_bets   (clear_bets),
        .spin_timeout (spin_timeout)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // kind: 0 write, 1 reject, 2 clear
    typedef struct {
        int         kind;
        int         cyc;
        logic [3:0] idx;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    int n_total = 0;
    int n_pass  = 0;

    // Round-level reference model, phases numbered as round_state reports them.
    int m_phase = 0;
    int m_count = 0;
    bit m_to    = 1'b0;
    int m_spin_entry = 0;
    int m_clear_cyc  = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic push(input int kind, input int c, input logic [3:0] idx, input logic [7:0] data);
        exp_t e;
        e.kind = kind; e.cyc = c; e.idx = idx; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic match(input int kind, input string name, input logic [3:0] idx, input logic [7:0] data);
        int found;
        longint act, req;
        found = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (found < 0 && exp_q[i].kind == kind) found = i;
        end
        act = (longint'(cyc) << 16) | (longint'(idx) << 8) | longint'(data);
        if (found < 0) begin
            chk(1'b0, {name, " unexpected"}, act, 0);
        end else begin
            req = (longint'(exp_q[found].cyc) << 16);
            if (kind == 0) req = req | (longint'(exp_q[found].idx) << 8) | longint'(exp_q[found].data);
            else act = (longint'(cyc) << 16);
            chk(act == req, name, act, req);
            $display("txn %s cycle=%0d idx=%0d data=0x%02h", name, cyc, idx, data);
            exp_q.delete(found);
        end
    endtask

    always @(negedge clock) begin
        if (bet_slot_we === 1'b1)  match(0, "write", bet_slot_idx, bet_slot_data);
        if (bet_rejected === 1'b1) match(1, "reject", 4'd0, 8'd0);
        if (clear_bets === 1'b1)   match(2, "clear", 4'd0, 8'd0);
    end

    // Predict the outcome of a key event sampled at cycle c.
    task automatic model_key(input logic [5:0] op, input logic [2:0] col, input bit done, input int c);
        if (op == 6'h3F) begin
        end else if (op == 6'h3E) begin
            if (m_phase == 1 && m_count >= 1) begin
                m_phase = 2; m_spin_entry = c; m_to = 1'b0;
            end else begin
                push(1, c, 4'd0, 8'd0);
            end
        end else begin
            if ((m_phase == 0 || m_phase == 1) && col != 3'd0 && m_count < MAXB) begin
                push(0, c, 4'(m_count), {col[1:0], op});
                m_count++;
                m_phase = 1;
            end else begin
                push(1, c, 4'd0, 8'd0);
            end
        end
        if (done && m_phase == 2 && c != m_spin_entry) begin
            m_phase = 3; m_clear_cyc = c + S_SET;
            push(2, m_clear_cyc, 4'd0, 8'd0);
        end
    endtask

    task automatic press(input logic [5:0] op, input logic [2:0] col, input bit done);
        @(posedge clock); #1;
        key_valid = 1'b1; bet_opcode = op; chip_color = col; spin_done = done;
        @(posedge clock); #1;
        model_key(op, col, done, cyc);
        key_valid = 1'b0; spin_done = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic check_state(input string tag);
        @(negedge clock);
        chk(round_state == 2'(m_phase), {tag, " round_state"}, round_state, m_phase);
        chk(spin_check == (m_phase == 2), {tag, " spin_check"}, spin_check, (m_phase == 2));
        chk(bet_count == 4'(m_count), {tag, " bet_count"}, bet_count, m_count);
        chk(spin_timeout == m_to, {tag, " spin_timeout"}, spin_timeout, m_to);
    endtask

    task automatic give_done(input int d);
        repeat (d) @(posedge clock);
        #1; spin_done = 1'b1;
        @(posedge clock); #1;
        spin_done = 1'b0;
        if (m_phase == 2) begin
            m_phase = 3; m_clear_cyc = cyc + S_SET;
            push(2, m_clear_cyc, 4'd0, 8'd0);
        end
    endtask

    task automatic run_timeout();
        int ex;
        ex = m_spin_entry + T_SPIN;
        while (cyc < ex - 1) begin @(posedge clock); #1; end
        check_state("last spin cycle");
        @(posedge clock); #1;
        m_phase = 3; m_to = 1'b1; m_clear_cyc = ex + S_SET;
        push(2, m_clear_cyc, 4'd0, 8'd0);
        check_state("timeout exit");
    endtask

    task automatic wait_clear();
        while (cyc < m_clear_cyc) begin @(posedge clock); #1; end
        m_phase = 0; m_count = 0;
        check_state("after clear");
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [5:0] op;
        logic [2:0] col;
        int n, sel;
        reset = 1'b0; key_valid = 1'b0; bet_opcode = 6'h3F; chip_color = 3'd0; spin_done = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk({bet_slot_we, bet_rejected, clear_bets, spin_check, spin_timeout} == 5'd0, "reset pulses", 0, 0);
        chk({bet_slot_idx, bet_slot_data, bet_count, round_state} == 18'd0, "reset values", 0, 0);
        @(posedge clock); #1 reset = 1'b1;
        check_state("post reset");

        // Bet then spin, completed by spin_done, with a reject in SETTLE.
        press(6'd5, 3'b001, 1'b0);
        check_state("bet accepted");
        press(6'h3E, 3'b000, 1'b0);
        check_state("spin entered");
        give_done(3);
        press(6'd7, 3'b001, 1'b0);
        check_state("settle");
        wait_clear();

        // Invalid events in IDLE.
        press(6'd9, 3'b000, 1'b0);
        press(6'h3E, 3'b011, 1'b0);
        press(6'h3F, 3'b011, 1'b0);
        check_state("invalid events");

        // Fill to capacity, overflow, spin out by timeout.
        for (int i = 0; i < 13; i++) press(6'(i + 1), 3'b010, 1'b0);
        check_state("full");
        press(6'h3E, 3'b000, 1'b0);
        run_timeout();
        wait_clear();

        // Key held for 10 cycles yields one event; key coinciding with spin_done is refused.
        @(posedge clock); #1;
        key_valid = 1'b1; bet_opcode = 6'd9; chip_color = 3'b011;
        @(posedge clock); #1;
        model_key(6'd9, 3'b011, 1'b0, cyc);
        repeat (9) @(posedge clock);
        #1 key_valid = 1'b0;
        check_state("held key");
        press(6'h3E, 3'b000, 1'b0);
        press(6'd4, 3'b001, 1'b1);
        check_state("done with key");
        wait_clear();

        // Reset in SPIN with a key held through release.
        press(6'd2, 3'b101, 1'b0);
        press(6'h3E, 3'b000, 1'b0);
        check_state("spin before reset");
        @(posedge clock); #1;
        reset = 1'b0; key_valid = 1'b1; bet_opcode = 6'd6; chip_color = 3'b001;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        m_phase = 0; m_count = 0; m_to = 1'b0;
        repeat (3) @(posedge clock);
        #1 key_valid = 1'b0;
        check_state("after mid-round reset");
        chk({bet_slot_idx, bet_slot_data} == 12'd0, "reset slot regs", {bet_slot_idx, bet_slot_data}, 0);

        // Randomised rounds.
        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(1, 14);
            for (int k = 0; k < n; k++) begin
                sel = $urandom_range(0, 11);
                if (sel == 0) op = 6'h3F;
                else if (sel == 1) op = 6'h3E;
                else op = 6'($urandom_range(0, 61));
                col = 3'($urandom_range(0, 7));
                press(op, col, 1'b0);
                if (m_phase == 2) break;
            end
            if (m_phase == 1) press(6'h3E, 3'd0, 1'b0);
            check_state("random round");
            if (m_phase == 2) begin
                if ($urandom_range(0, 1) == 1) give_done($urandom_range(0, 8));
                else run_timeout();
                wait_clear();
            end
        end

        repeat (4) @(posedge clock);
        chk(exp_q.size() == 0, "pending expected pulses", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
